// File: rtl/alu_share_arbiter_if.sv
// One requester link to the shared ALU: request channel and response channel,
// each with its own valid/ready handshake.
interface alu_share_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [DATA_W-1:0] req_rs1;
   logic [DATA_W-1:0] req_rs2;
   logic [DATA_W-1:0] req_imm;
   logic [12:0]       req_op;     // [12:11] alu_op, [10:4] funct7, [3:1] funct3, [0] alu_src
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_zero;

   // Requester side
   modport master (
      output req_valid, req_rs1, req_rs2, req_imm, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_zero
   );

   // Arbiter side
   modport slave (
      input  req_valid, req_rs1, req_rs2, req_imm, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_zero
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the core execute path (r0) and the
// debug/IO compute port (r1). One operation in flight: IDLE accepts,
// EXEC drives the ALU from registered operands, RESP returns the result.
module alu_share_arbiter #(
   parameter int DATA_W    = 32,
   parameter bit PRIO_MODE = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   alu_share_arbiter_if.slave r0,
   alu_share_arbiter_if.slave r1,
   output logic [DATA_W-1:0] alu_rd1,
   output logic [DATA_W-1:0] alu_rd2,
   output logic [DATA_W-1:0] alu_imm32,
   output logic              alu_src,
   output logic [1:0]        alu_op,
   output logic [2:0]        alu_funct3,
   output logic [6:0]        alu_funct7,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              busy,
   output logic              grant_id
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   logic              lp;         // last granted requester
   logic              busy_q;
   logic              gnt_q;
   logic [DATA_W-1:0] rs1_q;
   logic [DATA_W-1:0] rs2_q;
   logic [DATA_W-1:0] imm_q;
   logic [12:0]       op_q;
   logic              v0_q;
   logic              v1_q;
   logic [DATA_W-1:0] res0_q;
   logic [DATA_W-1:0] res1_q;
   logic              z0_q;
   logic              z1_q;

   logic              sel;        // requester chosen in IDLE
   logic              accept;     // a request is taken at the next edge
   logic              rsp_take;   // owner consumes the response

   // Arbitration and combinational request-ready; gated by reset so ready
   // drops at once when reset is asserted.
   always_comb begin
      if (r0.req_valid && r1.req_valid) begin
         sel = PRIO_MODE ? 1'b0 : ~lp;
      end else begin
         sel = r1.req_valid;
      end
      accept       = (state == IDLE) && !rst && (r0.req_valid || r1.req_valid);
      r0.req_ready = accept && !sel;
      r1.req_ready = accept &&  sel;
      rsp_take     = gnt_q ? r1.rsp_ready : r0.rsp_ready;
   end

   // Control FSM with operand, result and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         lp     <= 1'b1;
         busy_q <= 1'b0;
         gnt_q  <= 1'b0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         imm_q  <= '0;
         op_q   <= '0;
         v0_q   <= 1'b0;
         v1_q   <= 1'b0;
         res0_q <= '0;
         res1_q <= '0;
         z0_q   <= 1'b0;
         z1_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rs1_q  <= sel ? r1.req_rs1 : r0.req_rs1;
                  rs2_q  <= sel ? r1.req_rs2 : r0.req_rs2;
                  imm_q  <= sel ? r1.req_imm : r0.req_imm;
                  op_q   <= sel ? r1.req_op  : r0.req_op;
                  gnt_q  <= sel;
                  lp     <= sel;
                  busy_q <= 1'b1;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               // Only a subtract-type op defines the ALU zero flag.
               if (gnt_q) begin
                  res1_q <= alu_result;
                  z1_q   <= (op_q[12:11] == 2'b01) && alu_zero;
                  v1_q   <= 1'b1;
               end else begin
                  res0_q <= alu_result;
                  z0_q   <= (op_q[12:11] == 2'b01) && alu_zero;
                  v0_q   <= 1'b1;
               end
               state <= RESP;
            end
            RESP: begin
               if (rsp_take) begin
                  v0_q   <= 1'b0;
                  v1_q   <= 1'b0;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               v0_q   <= 1'b0;
               v1_q   <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   // Registered state to output ports.
   always_comb begin
      alu_rd1       = rs1_q;
      alu_rd2       = rs2_q;
      alu_imm32     = imm_q;
      alu_op        = op_q[12:11];
      alu_funct7    = op_q[10:4];
      alu_funct3    = op_q[3:1];
      alu_src       = op_q[0];
      busy          = busy_q;
      grant_id      = gnt_q;
      r0.rsp_valid  = v0_q;
      r0.rsp_result = res0_q;
      r0.rsp_zero   = z0_q;
      r1.rsp_valid  = v1_q;
      r1.rsp_result = res1_q;
      r1.rsp_zero   = z1_q;
   end

endmodule
